// File: rtl/hps_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : hps_cmd_sequencer
// Purpose  : HPS command front-end; decodes the control word and sequences
//            launch/run/done/ack handshakes to the systolic matrix core.
// Revision : 1.0 - initial release
// ============================================================================
module hps_cmd_sequencer #(
    parameter int         ADDR_WIDTH     = 16,
    parameter int         LEN_WIDTH      = 8,
    parameter logic [3:0] OPCODE_MATMUL  = 4'hA,
    parameter int         TIMEOUT_CYCLES = 4096
) (
    input  logic                  CLOCK,
    input  logic                  RESET_N,
    input  logic [31:0]           control_to_FPGA,
    output logic                  control_to_HPS,
    output logic                  core_start,
    output logic [3:0]            core_opcode,
    output logic [ADDR_WIDTH-1:0] core_base_addr,
    output logic [LEN_WIDTH-1:0]  core_len,
    output logic [7:0]            core_tile,
    input  logic                  core_done,
    output logic [31:0]           cycle_count,
    output logic                  err_flag
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_RUN    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [31:0] c_TIMEOUT = 32'(TIMEOUT_CYCLES);

    state_t                r_state;
    state_t                w_state_nxt;

    logic [31:0]           r_ctrl_q;
    logic [2:1]            r_ctrl_p;

    logic                  r_hps;
    logic                  r_start;
    logic [3:0]            r_opcode;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [7:0]            r_tile;
    logic [31:0]           r_cycle;
    logic                  r_err;

    logic                  w_hps_nxt;
    logic                  w_start_nxt;
    logic [3:0]            w_opcode_nxt;
    logic [ADDR_WIDTH-1:0] w_base_nxt;
    logic [LEN_WIDTH-1:0]  w_len_nxt;
    logic [7:0]            w_tile_nxt;
    logic [31:0]           w_cycle_nxt;
    logic                  w_err_nxt;

    logic                  w_soft_rst;
    logic                  w_go_rise;
    logic                  w_ack_rise;
    logic [3:0]            w_fld_opcode;
    logic [LEN_WIDTH-1:0]  w_fld_len;
    logic [ADDR_WIDTH-1:0] w_fld_base;
    logic [31:0]           w_cycle_inc;
    logic                  w_unused_rsvd;

    assign w_soft_rst    = r_ctrl_q[0];
    assign w_go_rise     = r_ctrl_q[1] & ~r_ctrl_p[1];
    assign w_ack_rise    = r_ctrl_q[2] & ~r_ctrl_p[2];
    assign w_fld_opcode  = r_ctrl_q[7:4];
    assign w_fld_len     = r_ctrl_q[8 +: LEN_WIDTH];
    assign w_fld_base    = r_ctrl_q[16 +: ADDR_WIDTH];
    assign w_unused_rsvd = r_ctrl_q[3];
    assign w_cycle_inc   = (r_cycle == 32'hFFFF_FFFF) ? r_cycle : r_cycle + 32'd1;

    // Edge-detect pipeline keeps tracking through a soft reset so a held go
    // bit cannot masquerade as a fresh edge afterwards.
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            r_ctrl_q <= 32'd0;
            r_ctrl_p <= 2'b00;
        end else begin
            r_ctrl_q <= control_to_FPGA;
            r_ctrl_p <= r_ctrl_q[2:1];
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET_N || w_soft_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_hps_nxt    = r_hps;
        w_start_nxt  = 1'b0;
        w_opcode_nxt = r_opcode;
        w_base_nxt   = r_base;
        w_len_nxt    = r_len;
        w_tile_nxt   = r_tile;
        w_cycle_nxt  = r_cycle;
        w_err_nxt    = r_err;

        case (r_state)
            S_IDLE: begin
                if (w_go_rise) begin
                    w_opcode_nxt = w_fld_opcode;
                    w_base_nxt   = w_fld_base;
                    w_len_nxt    = w_fld_len;
                    w_tile_nxt   = 8'd0;
                    w_err_nxt    = 1'b0;
                    if (w_fld_opcode == OPCODE_MATMUL) begin
                        w_state_nxt = S_LAUNCH;
                        w_start_nxt = 1'b1;
                        w_cycle_nxt = 32'd1;
                    end else begin
                        w_state_nxt = S_DONE;
                        w_hps_nxt   = 1'b1;
                        w_err_nxt   = 1'b1;
                    end
                end
            end

            S_LAUNCH: begin
                w_state_nxt = S_RUN;
                w_cycle_nxt = w_cycle_inc;
            end

            S_RUN: begin
                // A done arriving on the timeout cycle still counts as success.
                if (core_done) begin
                    w_state_nxt = S_DONE;
                    w_hps_nxt   = 1'b1;
                    w_cycle_nxt = w_cycle_inc;
                end else if (r_cycle == c_TIMEOUT) begin
                    w_state_nxt = S_DONE;
                    w_hps_nxt   = 1'b1;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_cycle_nxt = w_cycle_inc;
                end
            end

            S_DONE: begin
                if (w_ack_rise) begin
                    w_hps_nxt = 1'b0;
                    if (r_ctrl_q[1] && (r_opcode == OPCODE_MATMUL)) begin
                        w_state_nxt = S_LAUNCH;
                        w_start_nxt = 1'b1;
                        w_cycle_nxt = 32'd1;
                        w_err_nxt   = 1'b0;
                        w_base_nxt  = r_base + ADDR_WIDTH'(r_len);
                        w_tile_nxt  = r_tile + 8'd1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET_N || w_soft_rst) begin
            r_hps    <= 1'b0;
            r_start  <= 1'b0;
            r_opcode <= 4'd0;
            r_base   <= '0;
            r_len    <= '0;
            r_tile   <= 8'd0;
            r_cycle  <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            r_hps    <= w_hps_nxt;
            r_start  <= w_start_nxt;
            r_opcode <= w_opcode_nxt;
            r_base   <= w_base_nxt;
            r_len    <= w_len_nxt;
            r_tile   <= w_tile_nxt;
            r_cycle  <= w_cycle_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign control_to_HPS = r_hps;
    assign core_start     = r_start;
    assign core_opcode    = r_opcode;
    assign core_base_addr = r_base;
    assign core_len       = r_len;
    assign core_tile      = r_tile;
    assign cycle_count    = r_cycle;
    assign err_flag       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_hps_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hps_cmd_sequencer
// Purpose  : Scoreboard bench for hps_cmd_sequencer launch/done/ack sequencing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hps_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ctrl;
    logic        core_done;

    logic        control_to_HPS;
    logic        core_start;
    logic [3:0]  core_opcode;
    logic [15:0] core_base_addr;
    logic [7:0]  core_len;
    logic [7:0]  core_tile;
    logic [31:0] cycle_count;
    logic        err_flag;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] base;
        logic [7:0]  len;
        logic [7:0]  tile;
    } launch_t;

    launch_t exp_q[$];

    always #5 clk = ~clk;

    hps_cmd_sequencer #(
        .ADDR_WIDTH     (16),
        .LEN_WIDTH      (8),
        .OPCODE_MATMUL  (4'hA),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .CLOCK           (clk),
        .RESET_N         (rst_n),
        .control_to_FPGA (ctrl),
        .control_to_HPS  (control_to_HPS),
        .core_start      (core_start),
        .core_opcode     (core_opcode),
        .core_base_addr  (core_base_addr),
        .core_len        (core_len),
        .core_tile       (core_tile),
        .core_done       (core_done),
        .cycle_count     (cycle_count),
        .err_flag        (err_flag)
    );

    function automatic launch_t obs_launch();
        return {core_opcode, core_base_addr, core_len, core_tile};
    endfunction

    function automatic logic [70:0] obs_all();
        return {control_to_HPS, core_start, core_opcode, core_base_addr,
                core_len, core_tile, cycle_count, err_flag};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(output int n, output bit seen);
        n    = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            n++;
            if (core_start === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        ctrl      = 32'd0;
        core_done = 1'b0;
        repeat (3) tick();
        checks++;
        if (obs_all() !== 71'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", obs_all());
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_launch();
        int      n;
        bit      seen;
        launch_t e;
        ctrl = 32'h0800_40A2;
        exp_q.push_back({4'hA, 16'h0800, 8'h40, 8'h00});
        wait_start(n, seen);
        checks++;
        if (!seen || n != 2) begin
            errors++;
            $display("FAIL launch_latency: got seen=%0d edges=%0d want 2", seen, n);
        end
        if (seen && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_launch() !== e) begin
                errors++;
                $display("FAIL launch_fields: got %h want %h", obs_launch(), e);
            end
        end
        tick();
        checks++;
        if (core_start !== 1'b0) begin
            errors++;
            $display("FAIL start_width: got %b want 0", core_start);
        end
    endtask

    task automatic test_done_ack();
        launch_t e;
        repeat (8) tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        checks++;
        if (control_to_HPS !== 1'b1 || cycle_count !== 32'd11 || err_flag !== 1'b0) begin
            errors++;
            $display("FAIL done_state: got hps=%b cyc=%0d err=%b want 1 11 0",
                     control_to_HPS, cycle_count, err_flag);
        end
        repeat (3) tick();
        checks++;
        if (control_to_HPS !== 1'b1 || cycle_count !== 32'd11) begin
            errors++;
            $display("FAIL done_hold: got hps=%b cyc=%0d want 1 11", control_to_HPS, cycle_count);
        end
        ctrl = 32'h0800_40A6;
        tick();
        checks++;
        if (control_to_HPS !== 1'b1) begin
            errors++;
            $display("FAIL ack_early: got hps=%b want 1", control_to_HPS);
        end
        ctrl = 32'h0800_40A2;
        exp_q.push_back({4'hA, 16'h0840, 8'h40, 8'h01});
        tick();
        checks++;
        if (control_to_HPS !== 1'b0 || core_start !== 1'b1 || cycle_count !== 32'd1) begin
            errors++;
            $display("FAIL ack_relaunch: got hps=%b start=%b cyc=%0d want 0 1 1",
                     control_to_HPS, core_start, cycle_count);
        end
        if (core_start === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_launch() !== e) begin
                errors++;
                $display("FAIL continue_fields: got %h want %h", obs_launch(), e);
            end
        end
    endtask

    task automatic test_soft_reset();
        int      n;
        bit      seen;
        int      starts;
        launch_t e;
        repeat (2) tick();
        ctrl = 32'h0000_0001;
        repeat (2) tick();
        checks++;
        if (obs_all() !== 71'd0) begin
            errors++;
            $display("FAIL soft_reset_outputs: got %h want 0", obs_all());
        end
        ctrl = 32'h0000_0000;
        tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        tick();
        checks++;
        if (obs_all() !== 71'd0) begin
            errors++;
            $display("FAIL stray_done: got %h want 0", obs_all());
        end
        ctrl = 32'h0800_40A2;
        exp_q.push_back({4'hA, 16'h0800, 8'h40, 8'h00});
        wait_start(n, seen);
        checks++;
        if (!seen || n != 2) begin
            errors++;
            $display("FAIL fresh_latency: got seen=%0d edges=%0d want 2", seen, n);
        end
        if (seen && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_launch() !== e) begin
                errors++;
                $display("FAIL fresh_fields: got %h want %h", obs_launch(), e);
            end
        end
        tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        checks++;
        if (control_to_HPS !== 1'b1 || cycle_count !== 32'd3) begin
            errors++;
            $display("FAIL fresh_done: got hps=%b cyc=%0d want 1 3", control_to_HPS, cycle_count);
        end
        ctrl   = 32'h0000_0004;
        starts = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (core_start === 1'b1) starts++;
        end
        checks++;
        if (control_to_HPS !== 1'b0 || starts != 0) begin
            errors++;
            $display("FAIL ack_to_idle: got hps=%b starts=%0d want 0 0", control_to_HPS, starts);
        end
        ctrl = 32'h0000_0000;
        tick();
    endtask

    task automatic test_bad_opcode();
        int starts;
        ctrl   = 32'h0800_4052;
        starts = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (core_start === 1'b1) starts++;
        end
        checks++;
        if (starts != 0 || control_to_HPS !== 1'b1 || err_flag !== 1'b1 || core_opcode !== 4'h5) begin
            errors++;
            $display("FAIL bad_opcode: got starts=%0d hps=%b err=%b op=%h want 0 1 1 5",
                     starts, control_to_HPS, err_flag, core_opcode);
        end
        ctrl = 32'h0000_0004;
        repeat (2) tick();
        checks++;
        if (control_to_HPS !== 1'b0 || err_flag !== 1'b1) begin
            errors++;
            $display("FAIL bad_opcode_ack: got hps=%b err=%b want 0 1", control_to_HPS, err_flag);
        end
        ctrl = 32'h0000_0000;
        tick();
    endtask

    task automatic test_timeout();
        int      n;
        bit      seen;
        launch_t e;
        ctrl = 32'h0010_10A2;
        exp_q.push_back({4'hA, 16'h0010, 8'h10, 8'h00});
        wait_start(n, seen);
        if (seen && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_launch() !== e || err_flag !== 1'b0) begin
                errors++;
                $display("FAIL timeout_launch: got %h err=%b want %h err=0", obs_launch(), err_flag, e);
            end
        end else begin
            checks++;
            errors++;
            $display("FAIL timeout_launch: got no start want start");
        end
        repeat (15) tick();
        checks++;
        if (control_to_HPS !== 1'b0 || cycle_count !== 32'd16) begin
            errors++;
            $display("FAIL timeout_pre: got hps=%b cyc=%0d want 0 16", control_to_HPS, cycle_count);
        end
        tick();
        checks++;
        if (control_to_HPS !== 1'b1 || err_flag !== 1'b1 || cycle_count !== 32'd16) begin
            errors++;
            $display("FAIL timeout_fire: got hps=%b err=%b cyc=%0d want 1 1 16",
                     control_to_HPS, err_flag, cycle_count);
        end
        repeat (2) tick();
        checks++;
        if (cycle_count !== 32'd16) begin
            errors++;
            $display("FAIL timeout_hold: got cyc=%0d want 16", cycle_count);
        end
        ctrl = 32'h0000_0004;
        repeat (2) tick();
        ctrl = 32'h0000_0000;
        tick();
    endtask

    task automatic test_back_to_back();
        int          n;
        bit          seen;
        int          starts;
        launch_t     e;
        logic [15:0] exp_base;
        logic [7:0]  exp_tile;
        exp_base = 16'hC000;
        exp_tile = 8'h00;
        ctrl = 32'hC000_40A2;
        exp_q.push_back({4'hA, exp_base, 8'h40, exp_tile});
        wait_start(n, seen);
        if (seen && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_launch() !== e) begin
                errors++;
                $display("FAIL chain_first: got %h want %h", obs_launch(), e);
            end
        end else begin
            checks++;
            errors++;
            $display("FAIL chain_first: got no start want start");
        end
        for (int k = 1; k <= 255; k++) begin
            tick();
            core_done = 1'b1;
            tick();
            core_done = 1'b0;
            ctrl = 32'hC000_40A6;
            tick();
            ctrl     = 32'hC000_40A2;
            exp_base = exp_base + 16'h0040;
            exp_tile = exp_tile + 8'd1;
            exp_q.push_back({4'hA, exp_base, 8'h40, exp_tile});
            tick();
            checks++;
            if (core_start !== 1'b1 || exp_q.size() == 0) begin
                errors++;
                $display("FAIL chain_start: got start=%b at step %0d want 1", core_start, k);
            end else begin
                e = exp_q.pop_front();
                if (obs_launch() !== e) begin
                    errors++;
                    $display("FAIL chain_fields: got %h want %h at step %0d", obs_launch(), e, k);
                end
            end
        end
        tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        ctrl     = 32'hC000_40A6;
        exp_base = exp_base + 16'h0040;
        exp_tile = exp_tile + 8'd1;
        exp_q.push_back({4'hA, exp_base, 8'h40, exp_tile});
        starts = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) ctrl = 32'hC000_40A2;
            tick();
            if (core_start === 1'b1) begin
                starts++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checks++;
                    if (obs_launch() !== e) begin
                        errors++;
                        $display("FAIL wrap_fields: got %h want %h", obs_launch(), e);
                    end
                end
            end
        end
        checks++;
        if (starts != 1 || control_to_HPS !== 1'b0) begin
            errors++;
            $display("FAIL ack_held: got starts=%0d hps=%b want 1 0", starts, control_to_HPS);
        end
        ctrl = 32'h0000_0001;
        repeat (2) tick();
        ctrl = 32'h0000_0000;
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_launch();
        test_done_ack();
        test_soft_reset();
        test_bad_opcode();
        test_timeout();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hps_cmd_sequencer.md
# hps_cmd_sequencer

Command front-end between the HPS control register and the TPU matrix core. Registers the 32-bit `control_to_FPGA` word from the HPS and decodes its command fields. Runs a launch/run/done/acknowledge handshake that issues single-cycle start pulses to the 8x8 systolic core. Drives the `control_to_HPS` completion flag and auto-advances tile address on continued jobs.

## Interface
- `ADDR_WIDTH`, 16: base-address field width (`control_to_FPGA[31:16]`).
- `LEN_WIDTH`, 8: job-length field width (`control_to_FPGA[15:8]`).
- `OPCODE_MATMUL`, 4'hA: only supported opcode.
- `TIMEOUT_CYCLES`, 4096: watchdog limit for the RUN state.
- `CLOCK`  in  1  single clock; all logic on the rising edge.
- `RESET_N`  in  1  reset, synchronous, active-low.
- `control_to_FPGA`  in  32  HPS command word:
  - [0] soft reset
  - [1] go
  - [2] ack
  - [3] reserved, ignored
  - [7:4] opcode
  - [15:8] len
  - [31:16] base
- `control_to_HPS`  out  1  job complete; held until acked.
- `core_start`  out  1  one-cycle launch pulse to the core.
- `core_opcode`  out  4  latched opcode.
- `core_base_addr`  out  16  latched or advanced base address.
- `core_len`  out  8  latched length.
- `core_tile`  out  8  tile index of current job.
- `core_done`  in  1  core completion pulse.
- `cycle_count`  out  32  cycles spent in the last or current job.
- `err_flag`  out  1  bad opcode or watchdog expiry on the last job.

## Operation
- `control_to_FPGA` is registered into `ctrl_q` every cycle, and `ctrl_q` into `ctrl_p`.
- Rising-edge detects:
  - go_rise = `ctrl_q[1]` & ~`ctrl_p[1]`
  - ack_rise = `ctrl_q[2]` & ~`ctrl_p[2]`
- Priority order: `RESET_N`=0, then `ctrl_q[0]`=1 (soft reset), then the FSM.
- Reset and soft reset have the same effect:
  - state goes to IDLE.
  - All outputs go to 0, including the tile index and `cycle_count`.
  - Edge detectors are not cleared by soft reset: `ctrl_p` keeps tracking, so go held through a soft reset does not create an edge.
- FSM states: IDLE, LAUNCH, RUN, DONE.
- IDLE:
  - on go_rise, latch opcode, base and len from `ctrl_q`; set tile=0 and clear `err_flag`.
  - If opcode==`OPCODE_MATMUL`, go to LAUNCH.
  - Otherwise go to DONE with `err_flag`=1; `core_start` is never pulsed.
- LAUNCH:
  - lasts exactly one cycle with `core_start`=1.
  - `cycle_count` is loaded to 1; then go to RUN.
- RUN:
  - `cycle_count` increments every cycle, saturating at 2^32-1.
  - `core_done`=1 → DONE.
  - If `cycle_count`==`TIMEOUT_CYCLES` and `core_done` is not high that cycle → DONE with `err_flag`=1.
  - go falling during RUN does not abort the job.
- DONE:
  - `control_to_HPS`=1 and `cycle_count` holds.
  - On ack_rise, `control_to_HPS` clears.
  - If `ctrl_q[1]` (go) is still 1 and the latched opcode is valid → continuation:
    - `core_base_addr` += `core_len`, modulo 2^16.
    - `core_tile` += 1, wrapping 255→0.
    - go to LAUNCH.
  - Otherwise → IDLE.
- `core_done` is ignored outside RUN.
- go_rise is ignored outside IDLE.
- ack_rise is ignored outside DONE.
- Command fields are re-read only in IDLE; continuation reuses the latched opcode and len.

## Timing
- Every output is a register, and every output is 0 after reset.
- Launch latency:
  - go is first sampled into `ctrl_q` at edge E.
  - FSM enters LAUNCH at E+1; `core_start` is high for the cycle E+1..E+2.
  - FSM enters RUN at E+2.
- Done latency:
  - `core_done` is sampled high at edge D.
  - At D: FSM enters DONE and `control_to_HPS`=1.
  - `cycle_count` = cycles from the LAUNCH edge to D, inclusive of both.
- Ack latency:
  - ack is first sampled into `ctrl_q` at edge A.
  - `control_to_HPS` goes low at A+1.
  - On continuation, `core_start` is high A+1..A+2.
- Holding ack high does not retrigger; ack must drop and rise again.
- Simultaneous soft reset and any FSM event: soft reset wins.
- Simultaneous `core_done` and timeout: treated as normal done, `err_flag`=0.

## Test plan
- Reset then word 0x080040A2 → one `core_start` pulse two edges after sampling, with `core_opcode`=0xA, `core_base_addr`=0x0800, `core_len`=0x40, `core_tile`=0.
- `core_done` pulsed 10 cycles after `core_start` → `control_to_HPS`=1 and `cycle_count`=11. Then word 0x080040A6 for one cycle followed by 0x080040A2:
  - `control_to_HPS` clears.
  - A new `core_start` pulse follows, with base 0x0840 and tile 1.
- Word 0x00000001 mid-RUN → IDLE with all outputs 0. A later `core_done` is ignored. Then 0x080040A2 starts a fresh job with tile 0 and base 0x0800.
- Word 0x08004052 (opcode 5) → no `core_start`; `control_to_HPS`=1 and `err_flag`=1. Ack with go dropped → IDLE.
- `core_done` withheld with `TIMEOUT_CYCLES`=16 → DONE with `err_flag`=1 when `cycle_count`=16.
- Continuation at base 0xFFC0 with len 0x40 and tile 255 → base wraps to 0x0000 and tile wraps to 0. Ack held high for 5 cycles → exactly one relaunch.
